// File: rtl/alu_pkg.sv
// Shared definitions for the sequential balance-controller ALU: FSM states,
// default widths and the signed clamp helper used by both result paths.
package alu_pkg;

    localparam int DEF_DATA_W    = 16;
    localparam int DEF_SAT_W     = 12;
    localparam int DEF_MUL_W     = 15;
    localparam int DEF_MUL_SHIFT = 12;
    localparam int DEF_MUL_SAT_W = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        WAIT = 2'd2
    } alu_state_e;

    typedef logic signed [63:0] wide_t;

    typedef struct packed {
        wide_t value;
        logic  flag;
    } clamp_t;

    // Clamps a signed value into the range of a signed 'width'-bit number.
    function automatic clamp_t sat_clamp(input wide_t val, input int width);
        wide_t  maxV;
        wide_t  minV;
        clamp_t res;
        maxV      = (wide_t'(1) <<< (width - 1)) - wide_t'(1);
        minV      = -maxV - wide_t'(1);
        res.value = val;
        res.flag  = 1'b0;
        if (val > maxV) begin
            res.value = maxV;
            res.flag  = 1'b1;
        end else if (val < minV) begin
            res.value = minV;
            res.flag  = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle,
// product held stable with done set until the next start.
module alu_mul_iter #(
    parameter int MUL_W = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [MUL_W-1:0]     a,
    input  logic [MUL_W-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*MUL_W-1:0]   product
);

    localparam int CNT_W = (MUL_W > 1) ? $clog2(MUL_W) : 1;

    logic [2*MUL_W-1:0] r_mcand;
    logic [MUL_W-1:0]   r_mplier;
    logic [2*MUL_W-1:0] r_prod;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_done;

    // Start reloads everything and clears done, so a new operation can begin
    // on the same edge a previous product was consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else if (start) begin
            r_mcand  <= {{MUL_W{1'b0}}, a};
            r_mplier <= b;
            r_prod   <= '0;
            r_cnt    <= CNT_W'(MUL_W - 1);
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
        end else if (r_busy) begin
            if (r_mplier[0]) begin
                r_prod <= r_prod + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            if (r_cnt == '0) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end else begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign product = r_prod;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU between the PID sequencer and the motor-drive registers:
// single-cycle add/sub path, iterative multiply path, accumulator, valid/ready.
module alu_seq
    import alu_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int SAT_W     = DEF_SAT_W,
    parameter int MUL_W     = DEF_MUL_W,
    parameter int MUL_SHIFT = DEF_MUL_SHIFT,
    parameter int MUL_SAT_W = DEF_MUL_SAT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_vld,
    output logic              in_rdy,
    input  logic [DATA_W-1:0] src1,
    input  logic [DATA_W-1:0] src0,
    input  logic              acc_sel,
    input  logic              wr_acc,
    input  logic              sub,
    input  logic              mult2,
    input  logic              mult4,
    input  logic              saturate,
    input  logic              multiply,
    output logic [DATA_W-1:0] dst,
    output logic              sat_flag,
    output logic              dst_vld,
    input  logic              dst_rdy,
    output logic [DATA_W-1:0] acc
);

    alu_state_e r_state;
    alu_state_e w_nextState;

    logic [DATA_W-1:0] r_dst;
    logic              r_satFlag;
    logic              r_dstVld;
    logic [DATA_W-1:0] r_acc;
    logic              r_mulSign;
    logic              r_mulWrAcc;

    logic              w_outFree;
    logic              w_accept;
    logic              w_addCommit;
    logic              w_mulStart;
    logic              w_mulCommit;
    logic [DATA_W-1:0] w_src1;
    logic [DATA_W-1:0] w_src0s;
    logic [DATA_W-1:0] w_addend;
    logic [DATA_W-1:0] w_sum;
    clamp_t            w_addClamp;
    logic [DATA_W-1:0] w_addResult;
    logic              w_addFlag;

    logic [MUL_W-1:0]   w_mulA;
    logic [MUL_W-1:0]   w_mulB;
    logic [MUL_W-1:0]   w_aMag;
    logic [MUL_W-1:0]   w_bMag;
    logic               w_mulBusy;
    logic               w_mulDone;
    logic [2*MUL_W-1:0] w_prodMag;
    wide_t              w_prodSigned;
    wide_t              w_prodShift;
    clamp_t             w_mulClamp;
    logic [DATA_W-1:0]  w_mulResult;

    assign w_outFree   = ~r_dstVld | dst_rdy;
    assign in_rdy      = ~rst & (r_state == IDLE) & w_outFree;
    assign w_accept    = in_vld & in_rdy;
    assign w_addCommit = w_accept & ~multiply;

    // mult2 takes priority; the shifted value simply drops its top bits.
    assign w_src1  = acc_sel ? r_acc : src1;
    assign w_src0s = mult2 ? (src0 << 1) : (mult4 ? (src0 << 2) : src0);

    assign w_addend    = sub ? (~w_src0s + DATA_W'(1)) : w_src0s;
    assign w_sum       = w_src1 + w_addend;
    assign w_addClamp  = sat_clamp(wide_t'($signed(w_sum)), SAT_W);
    assign w_addResult = saturate ? w_addClamp.value[DATA_W-1:0] : w_sum;
    assign w_addFlag   = saturate & w_addClamp.flag;

    // Magnitudes fit MUL_W unsigned bits, so the most negative operand is exact.
    assign w_mulA = w_src1[MUL_W-1:0];
    assign w_mulB = w_src0s[MUL_W-1:0];
    assign w_aMag = w_mulA[MUL_W-1] ? (~w_mulA + MUL_W'(1)) : w_mulA;
    assign w_bMag = w_mulB[MUL_W-1] ? (~w_mulB + MUL_W'(1)) : w_mulB;

    alu_mul_iter #(
        .MUL_W (MUL_W)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (w_mulStart),
        .a       (w_aMag),
        .b       (w_bMag),
        .busy    (w_mulBusy),
        .done    (w_mulDone),
        .product (w_prodMag)
    );

    assign w_prodSigned = r_mulSign ? -wide_t'(w_prodMag) : wide_t'(w_prodMag);
    assign w_prodShift  = w_prodSigned >>> MUL_SHIFT;
    assign w_mulClamp   = sat_clamp(w_prodShift, MUL_SAT_W);
    assign w_mulResult  = w_mulClamp.value[DATA_W-1:0];

    // State register; reset mid-multiply simply drops the operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state, core start and multiply-result commit.
    always_comb begin
        w_nextState = r_state;
        w_mulStart  = 1'b0;
        w_mulCommit = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept && multiply) begin
                    w_mulStart  = 1'b1;
                    w_nextState = MUL;
                end
            end
            MUL: begin
                if (w_mulDone && !w_mulBusy) begin
                    if (w_outFree) begin
                        w_mulCommit = 1'b1;
                        w_nextState = IDLE;
                    end else begin
                        w_nextState = WAIT;
                    end
                end
            end
            WAIT: begin
                if (w_outFree) begin
                    w_mulCommit = 1'b1;
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Sign and accumulator-write intent for the multiply in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mulSign  <= 1'b0;
            r_mulWrAcc <= 1'b0;
        end else if (w_mulStart) begin
            r_mulSign  <= w_mulA[MUL_W-1] ^ w_mulB[MUL_W-1];
            r_mulWrAcc <= wr_acc;
        end
    end

    // Output register and accumulator; a new result may replace a retiring one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dst     <= '0;
            r_satFlag <= 1'b0;
            r_dstVld  <= 1'b0;
            r_acc     <= '0;
        end else if (w_addCommit) begin
            r_dst     <= w_addResult;
            r_satFlag <= w_addFlag;
            r_dstVld  <= 1'b1;
            if (wr_acc) begin
                r_acc <= w_addResult;
            end
        end else if (w_mulCommit) begin
            r_dst     <= w_mulResult;
            r_satFlag <= w_mulClamp.flag;
            r_dstVld  <= 1'b1;
            if (r_mulWrAcc) begin
                r_acc <= w_mulResult;
            end
        end else if (dst_rdy) begin
            r_dstVld <= 1'b0;
        end
    end

    assign dst      = r_dst;
    assign sat_flag = r_satFlag;
    assign dst_vld  = r_dstVld;
    assign acc      = r_acc;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed steps plus random operations
// compared against an arithmetic reference model.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_vld;
    logic        in_rdy;
    logic [15:0] src1;
    logic [15:0] src0;
    logic        acc_sel;
    logic        wr_acc;
    logic        sub;
    logic        mult2;
    logic        mult4;
    logic        saturate;
    logic        multiply;
    logic [15:0] dst;
    logic        sat_flag;
    logic        dst_vld;
    logic        dst_rdy;
    logic [15:0] acc;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] modelAcc;
    logic [15:0] expDst;
    logic        expFlag;

    always #5 clk = ~clk;

    alu_seq dut (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (in_vld),
        .in_rdy   (in_rdy),
        .src1     (src1),
        .src0     (src0),
        .acc_sel  (acc_sel),
        .wr_acc   (wr_acc),
        .sub      (sub),
        .mult2    (mult2),
        .mult4    (mult4),
        .saturate (saturate),
        .multiply (multiply),
        .dst      (dst),
        .sat_flag (sat_flag),
        .dst_vld  (dst_vld),
        .dst_rdy  (dst_rdy),
        .acc      (acc)
    );

    // Reference: plain integer arithmetic on the operation's definition.
    function automatic void refModel(input logic [15:0] a1, input logic [15:0] a0,
                                     input bit doSub, input bit m2, input bit m4,
                                     input bit sat, input bit mul,
                                     output logic [15:0] res, output logic flag);
        int     s0s;
        int     v;
        int     ma;
        int     mb;
        longint p;
        s0s  = m2 ? int'(a0) * 2 : (m4 ? int'(a0) * 4 : int'(a0));
        s0s  = s0s % 65536;
        flag = 1'b0;
        if (mul) begin
            ma = int'(a1) % 32768;
            if (ma >= 16384) ma = ma - 32768;
            mb = s0s % 32768;
            if (mb >= 16384) mb = mb - 32768;
            p = longint'(ma) * longint'(mb);
            p = p >>> 12;
            if (p > 16383) begin
                p = 16383;
                flag = 1'b1;
            end else if (p < -16384) begin
                p = -16384;
                flag = 1'b1;
            end
            res = p[15:0];
        end else begin
            v = doSub ? int'(a1) - s0s : int'(a1) + s0s;
            v = v & 32'hFFFF;
            if (v >= 32768) v = v - 65536;
            if (sat) begin
                if (v > 2047) begin
                    v = 2047;
                    flag = 1'b1;
                end else if (v < -2048) begin
                    v = -2048;
                    flag = 1'b1;
                end
            end
            res = v[15:0];
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Presents one operation, waits (bounded) for acceptance, updates the model.
    task automatic applyStimulus(input logic [15:0] a1, input logic [15:0] a0,
                                 input bit accSel, input bit wrAcc, input bit doSub,
                                 input bit m2, input bit m4, input bit sat, input bit mul);
        int guard = 0;
        src1 = a1; src0 = a0; acc_sel = accSel; wr_acc = wrAcc; sub = doSub;
        mult2 = m2; mult4 = m4; saturate = sat; multiply = mul;
        in_vld = 1'b1;
        while (!in_rdy && guard < 200) begin
            tick();
            guard++;
        end
        checkOutput("accept_wait", {31'b0, in_rdy}, 32'd1);
        refModel(accSel ? modelAcc : a1, a0, doSub, m2, m4, sat, mul, expDst, expFlag);
        if (wrAcc) modelAcc = expDst;
        tick();
        in_vld = 1'b0;
    endtask

    task automatic waitResult(output int cycles);
        cycles = 0;
        while (!dst_vld && cycles < 100) begin
            tick();
            cycles++;
        end
        checkOutput("result_wait", {31'b0, dst_vld}, 32'd1);
    endtask

    task automatic checkResult(input string tag);
        checkOutput({tag, "_dst"}, {16'b0, dst}, {16'b0, expDst});
        checkOutput({tag, "_flag"}, {31'b0, sat_flag}, {31'b0, expFlag});
        checkOutput({tag, "_acc"}, {16'b0, acc}, {16'b0, modelAcc});
    endtask

    task automatic doReset();
        rst = 1'b1;
        in_vld = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        modelAcc = 16'h0000;
        tick();
    endtask

    initial begin
        int cyc;
        int extraVld;
        logic [15:0] heldDst;
        logic [15:0] ra1;
        logic [15:0] ra0;

        rst = 1'b1; in_vld = 1'b0; src1 = '0; src0 = '0; acc_sel = 1'b0; wr_acc = 1'b0;
        sub = 1'b0; mult2 = 1'b0; mult4 = 1'b0; saturate = 1'b0; multiply = 1'b0;
        dst_rdy = 1'b1; modelAcc = 16'h0000;
        tick();
        tick();
        checkOutput("rst_dst", {16'b0, dst}, 32'd0);
        checkOutput("rst_flag", {31'b0, sat_flag}, 32'd0);
        checkOutput("rst_vld", {31'b0, dst_vld}, 32'd0);
        checkOutput("rst_acc", {16'b0, acc}, 32'd0);
        checkOutput("rst_inrdy", {31'b0, in_rdy}, 32'd0);
        rst = 1'b0;
        tick();
        checkOutput("post_rst_inrdy", {31'b0, in_rdy}, 32'd1);

        // Basic add, both clamp directions, plain wrap and pre-scale.
        applyStimulus(16'h0100, 16'h0023, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("add_vld", {31'b0, dst_vld}, 32'd1);
        checkResult("add");
        applyStimulus(16'h0700, 16'h0200, 0, 0, 0, 0, 0, 1, 0);
        checkResult("sat_pos");
        applyStimulus(16'hF900, 16'h0200, 0, 0, 1, 0, 0, 1, 0);
        checkResult("sat_neg");
        applyStimulus(16'h7FFF, 16'h0001, 0, 0, 0, 0, 0, 0, 0);
        checkResult("wrap");
        applyStimulus(16'h0010, 16'h0003, 0, 0, 1, 1, 1, 0, 0);
        checkResult("sub_mult2");
        applyStimulus(16'h0010, 16'h4003, 0, 0, 0, 0, 1, 0, 0);
        checkResult("add_mult4");

        // Multiply latency and clamp.
        applyStimulus(16'h1000, 16'h0800, 0, 0, 0, 0, 0, 0, 1);
        waitResult(cyc);
        checkOutput("mul_latency", cyc, 32'd16);
        checkResult("mul_pos");
        applyStimulus(16'hF000, 16'h0800, 0, 0, 0, 0, 0, 0, 1);
        waitResult(cyc);
        checkResult("mul_neg");
        applyStimulus(16'h3FFF, 16'h3FFF, 0, 0, 0, 0, 0, 0, 1);
        waitResult(cyc);
        checkResult("mul_sat");
        applyStimulus(16'h4000, 16'h4000, 0, 0, 0, 0, 0, 0, 1);
        waitResult(cyc);
        checkResult("mul_minop");

        // Random mix including accumulator reuse.
        for (int i = 0; i < 40; i++) begin
            ra1 = 16'($urandom);
            ra0 = 16'($urandom);
            if ($urandom_range(0, 4) == 0) ra0 = 16'h4000;
            applyStimulus(ra1, ra0, 1'($urandom), 1'($urandom), 1'($urandom),
                          1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 2) == 0);
            waitResult(cyc);
            checkResult("rand");
        end
        tick();

        // Backpressure on an add result, then on a multiply result.
        dst_rdy = 1'b0;
        applyStimulus(16'h0123, 16'h0011, 0, 0, 0, 0, 0, 0, 0);
        heldDst = expDst;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("bp_add_hold", {16'b0, dst}, {16'b0, heldDst});
            checkOutput("bp_add_vld", {31'b0, dst_vld}, 32'd1);
            checkOutput("bp_add_inrdy", {31'b0, in_rdy}, 32'd0);
        end
        dst_rdy = 1'b1;
        applyStimulus(16'h2000, 16'hE000, 0, 0, 0, 0, 0, 0, 1);
        dst_rdy = 1'b0;
        checkOutput("bp_mul_busy_inrdy", {31'b0, in_rdy}, 32'd0);
        waitResult(cyc);
        checkOutput("bp_mul_latency", cyc, 32'd16);
        heldDst = expDst;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("bp_mul_hold", {16'b0, dst}, {16'b0, heldDst});
            checkOutput("bp_mul_inrdy", {31'b0, in_rdy}, 32'd0);
        end
        dst_rdy = 1'b1;
        applyStimulus(16'h0042, 16'h0001, 0, 0, 1, 0, 0, 0, 0);
        checkOutput("bp_retire_accept_vld", {31'b0, dst_vld}, 32'd1);
        checkResult("bp_retire_accept");

        // Accumulate chains from reset.
        doReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(16'($urandom), 16'h0010, 1, 1, 0, 0, 0, 0, 0);
            checkResult("acc_add");
        end
        checkOutput("acc_add3", {16'b0, acc}, 32'h0000_0030);
        doReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(16'($urandom), 16'h0010, 1, 1, 1, 0, 0, 0, 0);
            checkResult("acc_sub");
        end
        checkOutput("acc_sub3", {16'b0, acc}, 32'h0000_FFD0);

        // Reset in the middle of a multiply.
        applyStimulus(16'h1000, 16'h0800, 0, 1, 0, 0, 0, 0, 1);
        repeat (5) tick();
        rst = 1'b1;
        #1;
        checkOutput("midrst_vld", {31'b0, dst_vld}, 32'd0);
        checkOutput("midrst_acc", {16'b0, acc}, 32'd0);
        checkOutput("midrst_dst", {16'b0, dst}, 32'd0);
        tick();
        rst = 1'b0;
        modelAcc = 16'h0000;
        tick();
        checkOutput("midrst_inrdy", {31'b0, in_rdy}, 32'd1);
        extraVld = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (dst_vld) extraVld++;
        end
        checkOutput("midrst_no_stale", extraVld, 32'd0);
        checkOutput("midrst_acc_after", {16'b0, acc}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
